// File: rtl/alu_issue_arbiter_if.sv
// Request/issue/writeback bundle between the two VLIW slots and the shared ALU issue arbiter.
// The master side drives the slot requests; the slave side is the arbiter.
interface alu_issue_arbiter_if;
    logic       hold;
    logic       s0_valid;
    logic [7:0] s0_code;
    logic       s0_ready;
    logic       s1_valid;
    logic [7:0] s1_code;
    logic       s1_ready;
    logic       issue_valid;
    logic [7:0] issue_code;
    logic       issue_slot;
    logic       wb_valid;
    logic [1:0] wb_reg;
    logic       wb_slot;
    logic [3:0] busy;

    modport master (
        output hold,
        output s0_valid,
        output s0_code,
        output s1_valid,
        output s1_code,
        input  s0_ready,
        input  s1_ready,
        input  issue_valid,
        input  issue_code,
        input  issue_slot,
        input  wb_valid,
        input  wb_reg,
        input  wb_slot,
        input  busy
    );

    modport slave (
        input  hold,
        input  s0_valid,
        input  s0_code,
        input  s1_valid,
        input  s1_code,
        output s0_ready,
        output s1_ready,
        output issue_valid,
        output issue_code,
        output issue_slot,
        output wb_valid,
        output wb_reg,
        output wb_slot,
        output busy
    );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter sharing one fixed-latency ALU between two VLIW slots,
// with a 4-entry register scoreboard blocking RAW/WAW hazards.
module alu_issue_arbiter #(
    parameter int unsigned LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_issue_arbiter_if.slave bus
);

    logic [3:0]            busy_q, busy_d;
    logic                  rr_last_q, rr_last_d;
    logic                  issue_valid_q, issue_valid_d;
    logic [7:0]            issue_code_q, issue_code_d;
    logic                  issue_slot_q, issue_slot_d;
    logic [LAT-1:0]        pv_q, pv_d;
    logic [LAT-1:0][1:0]   pdst_q, pdst_d;
    logic [LAT-1:0]        pslot_q, pslot_d;

    logic                  wb_valid;
    logic [1:0]            wb_reg;
    logic [3:0]            wb_onehot;
    logic [3:0]            blk;
    logic                  elig0, elig1;
    logic                  gnt_any;
    logic                  gnt_slot;
    logic [7:0]            gnt_code;

    assign wb_valid = pv_q[LAT-1];
    assign wb_reg   = pdst_q[LAT-1];

    // A register finishing writeback this cycle is treated as free (writeback bypass).
    always_comb begin
        wb_onehot = 4'b0000;
        if (wb_valid) begin
            wb_onehot[wb_reg] = 1'b1;
        end
        blk = busy_q & ~wb_onehot;
    end

    // Source 1 doubles as the destination, so this covers both RAW and WAW.
    assign elig0 = bus.s0_valid & ~bus.hold & ~blk[bus.s0_code[7:6]] & ~blk[bus.s0_code[5:4]];
    assign elig1 = bus.s1_valid & ~bus.hold & ~blk[bus.s1_code[7:6]] & ~blk[bus.s1_code[5:4]];

    assign gnt_any  = elig0 | elig1;
    assign gnt_slot = (elig0 & elig1) ? ~rr_last_q : elig1;
    assign gnt_code = gnt_slot ? bus.s1_code : bus.s0_code;

    assign bus.s0_ready = gnt_any & ~gnt_slot;
    assign bus.s1_ready = gnt_any &  gnt_slot;

    always_comb begin
        busy_d = busy_q;
        if (wb_valid) begin
            busy_d[wb_reg] = 1'b0;
        end
        // Applied after the clear so a new writer keeps the bit set.
        if (gnt_any) begin
            busy_d[gnt_code[7:6]] = 1'b1;
        end
    end

    always_comb begin
        rr_last_d     = gnt_any ? gnt_slot : rr_last_q;
        issue_valid_d = gnt_any;
        issue_code_d  = gnt_any ? gnt_code : issue_code_q;
        issue_slot_d  = gnt_any ? gnt_slot : issue_slot_q;
    end

    always_comb begin
        pv_d       = pv_q;
        pdst_d     = pdst_q;
        pslot_d    = pslot_q;
        pv_d[0]    = issue_valid_q;
        pdst_d[0]  = issue_valid_q ? issue_code_q[7:6] : 2'b00;
        pslot_d[0] = issue_valid_q & issue_slot_q;
        for (int i = 1; i < LAT; i++) begin
            pv_d[i]    = pv_q[i-1];
            pdst_d[i]  = pdst_q[i-1];
            pslot_d[i] = pslot_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q        <= 4'b0000;
            rr_last_q     <= 1'b1;
            issue_valid_q <= 1'b0;
            issue_code_q  <= 8'h00;
            issue_slot_q  <= 1'b0;
            pv_q          <= '0;
            pdst_q        <= '0;
            pslot_q       <= '0;
        end else begin
            busy_q        <= busy_d;
            rr_last_q     <= rr_last_d;
            issue_valid_q <= issue_valid_d;
            issue_code_q  <= issue_code_d;
            issue_slot_q  <= issue_slot_d;
            pv_q          <= pv_d;
            pdst_q        <= pdst_d;
            pslot_q       <= pslot_d;
        end
    end

    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_code  = issue_code_q;
    assign bus.issue_slot  = issue_slot_q;
    assign bus.wb_valid    = wb_valid;
    assign bus.wb_reg      = wb_reg;
    assign bus.wb_slot     = pslot_q[LAT-1];
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter: hand-derived ready expectations per cycle, with issue,
// writeback and scoreboard outputs checked against a queue-based model of the pipeline.
module tb_alu_issue_arbiter;

    localparam int unsigned LAT = 2;

    typedef struct {
        int         cyc;
        logic [7:0] code;
        logic       slot;
    } iss_t;

    typedef struct {
        int         cyc;
        logic [1:0] dst;
        logic       slot;
    } wb_t;

    logic clk;
    logic rst_n;

    alu_issue_arbiter_if bus ();

    alu_issue_arbiter #(.LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_run;
    int         n_fail;
    int         now;
    iss_t       iq[$];
    wb_t        wq[$];
    logic [3:0] exp_busy;
    logic [7:0] last_code;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, now, obs, exp);
        end
    endtask

    task automatic push_accept(input logic [7:0] code, input logic slot);
        iss_t ie;
        wb_t  we;
        ie.cyc  = now + 1;
        ie.code = code;
        ie.slot = slot;
        we.cyc  = now + 1 + int'(LAT);
        we.dst  = code[7:6];
        we.slot = slot;
        iq.push_back(ie);
        wq.push_back(we);
    endtask

    // One clock cycle: check outputs at the falling edge, advance the model, step past the edge.
    task automatic cyc(input logic exp_r0, input logic exp_r1);
        logic [3:0] nb;
        logic       iv;
        logic       wv;
        iss_t       ie;
        wb_t        we;
        @(negedge clk);
        chk("s0_ready", 8'(bus.s0_ready), 8'(exp_r0));
        chk("s1_ready", 8'(bus.s1_ready), 8'(exp_r1));
        iv = (iq.size() > 0) && (iq[0].cyc == now);
        chk("issue_valid", 8'(bus.issue_valid), 8'(iv));
        if (iv) begin
            ie = iq.pop_front();
            last_code = ie.code;
            chk("issue_slot", 8'(bus.issue_slot), 8'(ie.slot));
        end
        chk("issue_code", bus.issue_code, last_code);
        wv = (wq.size() > 0) && (wq[0].cyc == now);
        chk("wb_valid", 8'(bus.wb_valid), 8'(wv));
        nb = exp_busy;
        if (wv) begin
            we = wq.pop_front();
            chk("wb_reg", 8'(bus.wb_reg), 8'(we.dst));
            chk("wb_slot", 8'(bus.wb_slot), 8'(we.slot));
            nb[we.dst] = 1'b0;
        end
        chk("busy", 8'(bus.busy), 8'(exp_busy));
        if (bus.s0_valid && exp_r0) begin
            push_accept(bus.s0_code, 1'b0);
            nb[bus.s0_code[7:6]] = 1'b1;
        end
        if (bus.s1_valid && exp_r1) begin
            push_accept(bus.s1_code, 1'b1);
            nb[bus.s1_code[7:6]] = 1'b1;
        end
        exp_busy = nb;
        @(posedge clk);
        #1;
        now++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " issue_valid"}, 8'(bus.issue_valid), 8'h00);
        chk({tag, " issue_code"},  bus.issue_code,       8'h00);
        chk({tag, " issue_slot"},  8'(bus.issue_slot),  8'h00);
        chk({tag, " wb_valid"},    8'(bus.wb_valid),    8'h00);
        chk({tag, " wb_reg"},      8'(bus.wb_reg),      8'h00);
        chk({tag, " wb_slot"},     8'(bus.wb_slot),     8'h00);
        chk({tag, " busy"},        8'(bus.busy),        8'h00);
    endtask

    task automatic idle_inputs();
        bus.hold     = 1'b0;
        bus.s0_valid = 1'b0;
        bus.s0_code  = 8'h00;
        bus.s1_valid = 1'b0;
        bus.s1_code  = 8'h00;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        iq.delete();
        wq.delete();
        exp_busy  = 4'b0000;
        last_code = 8'h00;
        now       = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] d0;
        logic [1:0] d1;
        int         i0;
        int         i1;
        n_run  = 0;
        n_fail = 0;
        now    = 0;
        rst_n  = 1'b1;
        idle_inputs();
        #2;

        // Single op: dst B, src A, op 3; writeback LAT cycles after issue.
        do_reset();
        bus.s0_valid = 1'b1;
        bus.s0_code  = 8'h43;
        cyc(1'b1, 1'b0);
        bus.s0_valid = 1'b0;
        repeat (4) cyc(1'b0, 1'b0);

        // Both slots always requesting, hazard-free rotating destinations: strict alternation.
        do_reset();
        i0 = 0;
        i1 = 0;
        for (int k = 0; k < 8; k++) begin
            d0 = i0[0] ? 2'd2 : 2'd0;
            d1 = i1[0] ? 2'd3 : 2'd1;
            bus.s0_valid = 1'b1;
            bus.s0_code  = {d0, d0, 4'(i0)};
            bus.s1_valid = 1'b1;
            bus.s1_code  = {d1, d1, 4'(i1)};
            cyc(k % 2 == 0, k % 2 == 1);
            if (k % 2 == 0) i0++;
            else i1++;
        end
        idle_inputs();
        repeat (4) cyc(1'b0, 1'b0);

        // RAW on A: dependent held until the producer's writeback cycle.
        do_reset();
        bus.s0_valid = 1'b1;
        bus.s0_code  = 8'h01;
        cyc(1'b1, 1'b0);
        bus.s0_valid = 1'b0;
        bus.s1_valid = 1'b1;
        bus.s1_code  = 8'hC0;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        bus.s1_valid = 1'b0;
        repeat (4) cyc(1'b0, 1'b0);

        // hold for 3 cycles with one op in flight.
        do_reset();
        bus.s0_valid = 1'b1;
        bus.s0_code  = 8'h01;
        cyc(1'b1, 1'b0);
        bus.hold     = 1'b1;
        bus.s0_code  = 8'h50;
        bus.s1_valid = 1'b1;
        bus.s1_code  = 8'hAF;
        repeat (3) cyc(1'b0, 1'b0);
        bus.hold = 1'b0;
        cyc(1'b0, 1'b1);
        bus.s1_valid = 1'b0;
        cyc(1'b1, 1'b0);
        bus.s0_valid = 1'b0;
        repeat (4) cyc(1'b0, 1'b0);

        // Same destination D from both slots: slot 1 waits for slot 0's writeback.
        do_reset();
        bus.s0_valid = 1'b1;
        bus.s0_code  = 8'hF1;
        bus.s1_valid = 1'b1;
        bus.s1_code  = 8'hF2;
        cyc(1'b1, 1'b0);
        bus.s0_valid = 1'b0;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        bus.s1_valid = 1'b0;
        chk("busy[3] after same-edge set/clear", 8'(bus.busy), 8'h08);
        repeat (4) cyc(1'b0, 1'b0);

        // Reset one cycle after an issue: everything clears at once, no stray writeback.
        do_reset();
        bus.s0_valid = 1'b1;
        bus.s0_code  = 8'h43;
        cyc(1'b1, 1'b0);
        bus.s0_valid = 1'b0;
        cyc(1'b0, 1'b0);
        do_reset();
        repeat (5) cyc(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
